fetch_sequencer: RTL

//  Sequences instruction fetch around the program counter: owns the fetch PC, issues one

---
 rtl/fetch_sequencer.sv | 81 ++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, issues one imem request at a time, hands words to decode, applies redirects
module fetch_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] pc,
    output logic            misaligned
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;
    logic [1:0]      state;
    logic [XLEN-1:0] pc_inflight;
    logic            kill;
    logic            accept;
    logic            rsp;
    logic            bad_target;
    logic            keep_wait;
    always_comb begin
        imem_req_valid = (state == S_REQ) && (!inst_valid || !stall);
        imem_req_addr  = pc;
        accept         = imem_req_valid && imem_req_ready;
        rsp            = (state == S_WAIT) && imem_rsp_valid;
        bad_target     = |redirect_pc[1:0];
        // a redirect leaves a live request behind: the word still coming back must be dropped
        keep_wait      = accept || ((state == S_WAIT) && !rsp);
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            pc_inflight <= '0;
            kill        <= 1'b0;
            inst_valid  <= 1'b0;
            inst        <= '0;
            inst_pc     <= '0;
            misaligned  <= 1'b0;
        end else if (state != S_FAULT) begin
            if (redirect_valid && bad_target) begin
                misaligned <= 1'b1;
                inst_valid <= 1'b0;
                state      <= S_FAULT;
            end else if (redirect_valid) begin
                pc         <= redirect_pc;
                inst_valid <= 1'b0;
                kill       <= keep_wait;
                state      <= keep_wait ? S_WAIT : S_REQ;
            end else begin
                if (rsp && !kill) begin
                    inst_valid <= 1'b1;
                    inst       <= imem_rsp_data;
                    inst_pc    <= pc_inflight;
                end else if (!stall) begin
                    inst_valid <= 1'b0;
                end
                if (rsp) kill <= 1'b0;
                if (accept) begin
                    pc          <= pc + XLEN'(4);
                    pc_inflight <= pc;
                end
                state <= (state == S_IDLE) ? S_REQ :
                         accept            ? S_WAIT :
                         rsp               ? S_REQ : state;
            end
        end
    end
endmodule
